nco_phase_gen: RTL and testbench
================================

# nco_phase_gen

Phase-generation front end for the CORDIC NCO. It accumulates a programmable frequency tuning word (FTW) once per clock-enable and adds a programmable phase offset. The result drives the NCO's `i_phase` input. FTW and offset are loaded one byte at a time from the 8-bit pad bus, with an atomic commit, so a tile with narrow I/O can retune without glitching the output phase.

## Interface

Parameters:
- `PW`, 24: phase width in bits; must be a multiple of 8.
- `NB`, `PW/8`: bytes per configuration word; derived, not overridden.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `i_ce`, in, 1: advance enable; the same enable that drives the NCO.
- `i_cfg_valid`, in, 1: configuration byte valid.
- `i_cfg_sel`, in, 1: target register; 0 = FTW, 1 = phase offset (POFF).
- `i_cfg_data`, in, 8: configuration byte, LSB byte first.
- `o_cfg_ready`, out, 1: loader can accept a byte.
- `o_cfg_commit`, out, 1: one-cycle pulse when a word is written to the active register.
- `i_phase_clr`, in, 1: synchronous clear of the accumulator.
- `o_phase`, out, PW: phase to the NCO, equal to acc + POFF mod 2^PW.
- `o_valid`, out, 1: `o_phase` updated this cycle.
- `o_wrap`, out, 1: the accumulator carried out on the sample now shown on `o_phase`.

## Operation

**Loader FSM** (IDLE, LOAD, COMMIT):
- A byte is accepted when `i_cfg_valid && o_cfg_ready`.
- `o_cfg_ready` = `!reset && state != COMMIT`.
- IDLE: an accepted byte is written to shadow[7:0]. `i_cfg_sel` is latched, the byte count is set to 1, and the FSM goes to LOAD. If NB==1, it goes directly to COMMIT.
- LOAD: an accepted byte with the same sel is written to shadow[8k+7:8k], and the count increments. The byte that makes count==NB moves the FSM to COMMIT.
- LOAD, sel mismatch: the partial word is discarded. The mismatching byte becomes byte 0 of a new word with the new sel, and the FSM stays in LOAD.
- COMMIT (one cycle): shadow is copied to FTW or POFF per the latched sel, `o_cfg_commit`=1, the FSM returns to IDLE, and the count is cleared.
- Active FTW/POFF never hold a partially loaded word.

**Accumulator pipeline:**
- Stage 1, on `i_ce`: acc ← acc + FTW mod 2^PW; carry_d ← carry-out; v1 ← 1. When `i_ce`=0: acc holds and v1 ← 0.
- Stage 2, every cycle: o_valid ← v1. If v1: o_phase ← acc + POFF mod 2^PW and o_wrap ← carry_d; otherwise o_phase holds and o_wrap ← 0.
- `i_phase_clr` has priority over the add: acc ← 0 and carry_d ← 0. v1 still follows `i_ce`.
- A POFF change is visible on the next stage-2 update. It never disturbs acc.

**Reset:**
- acc, FTW, POFF, shadow, count, carry_d and v1 are cleared; the FSM goes to IDLE.
- Outputs: `o_phase`=0, `o_valid`=0, `o_wrap`=0, `o_cfg_commit`=0, `o_cfg_ready`=0 while reset is high and 1 from the first cycle after.
- Reset in the middle of a load discards the partial word.

## Timing

- Latency from `i_ce` sampled at edge E to `o_phase`/`o_valid`/`o_wrap` registered at edge E+1: visible 2 cycles after `i_ce` is presented.
- Commit: the final byte is accepted at edge E. COMMIT is held during the following cycle, `o_cfg_commit` is high in that cycle, and the active register is written at edge E+1.
- A new FTW is first used by the `i_ce` sampled at edge E+2 or later.
- During COMMIT, `o_cfg_ready`=0 and a presented byte is not accepted; the source holds it. Maximum throughput is NB bytes per NB+1 cycles.
- Configuration and accumulation are independent. `i_ce` may be active during loads, and `i_ce` and commit may occur in the same cycle; the add uses the old FTW.
- Wrap-around: the acc sum is taken modulo 2^PW with no saturation. A carry-out sets `o_wrap` for exactly one `o_valid` sample.
- All outputs are registered; there is no combinational path from inputs to `o_phase`.

## Test plan

1. **Basic accumulate.** Reset, load FTW bytes 0x00, 0x01, 0x00 (sel=0). Expect `o_cfg_commit` high for 1 cycle. With `i_ce` held high, `o_phase` reads 0x000100, 0x000200, 0x000300…, with `o_valid`=1 starting 2 cycles after the first `i_ce`.
2. **Wrap.** FTW=0x800000, `i_ce` continuous. `o_phase` alternates 0x800000 and 0x000000, and `o_wrap`=1 exactly on the 0x000000 samples.
3. **Offset.** While test 1 is running, load POFF=0x400000. Each subsequent `o_phase` is exactly 0x400000 above the un-offset sequence, and the acc progression is unchanged.
4. **Sel-switch abort.** Send FTW byte 0xAA (sel=0), then bytes 0x11, 0x22, 0x33 (sel=1). Expect one commit, POFF=0x332211, FTW unchanged.
5. **Clear and gaps.** Assert `i_phase_clr` together with `i_ce` → the next `o_phase` equals POFF. With `i_ce` toggled 1,0,1 → `o_valid` pattern 1,0,1 two cycles later, and `o_phase` holds during the 0.
6. **Reset mid-load.** Send 2 FTW bytes, then pulse reset. FTW=0, `o_phase`=0, `o_cfg_ready`=0 during reset and 1 after. A fresh 3-byte load then commits normally.

Source files
------------

// File: rtl/nco_phase_gen.sv
// Phase accumulator front end for the CORDIC NCO.
// FTW/offset are byte-loaded into a shadow word and committed atomically.
module nco_phase_gen #(
    parameter int PW = 24,
    localparam int NB = PW / 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_ce,
    input  logic          i_cfg_valid,
    input  logic          i_cfg_sel,
    input  logic [7:0]    i_cfg_data,
    output logic          o_cfg_ready,
    output logic          o_cfg_commit,
    input  logic          i_phase_clr,
    output logic [PW-1:0] o_phase,
    output logic          o_valid,
    output logic          o_wrap
);

    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          sel_q;
    logic [PW-1:0] shadow;
    logic [PW-1:0] ftw;
    logic [PW-1:0] poff;
    logic [PW-1:0] acc;
    logic          carry_d;
    logic          v1;
    logic          accept;
    logic          first_byte;
    logic [CW-1:0] wr_idx;
    logic [PW:0]   sum;

    assign accept = i_cfg_valid && o_cfg_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = (NB == 1) ? COMMIT : LOAD;
            end
            LOAD: begin
                if (accept && (i_cfg_sel == sel_q) &&
                    (cnt == CW'(NB - 1)))
                    state_nx = COMMIT;
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_cfg_ready  = !reset && (state != COMMIT);
        o_cfg_commit = !reset && (state == COMMIT);
    end

    // A sel change mid-word restarts the word at byte 0.
    assign first_byte = (state == IDLE) || (i_cfg_sel != sel_q);
    assign wr_idx     = first_byte ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            cnt    <= '0;
            sel_q  <= 1'b0;
            ftw    <= '0;
            poff   <= '0;
        end else if (state == COMMIT) begin
            cnt <= '0;
            if (sel_q) poff <= shadow;
            else       ftw  <= shadow;
        end else if (accept) begin
            sel_q <= i_cfg_sel;
            cnt   <= first_byte ? CW'(1) : cnt + 1'b1;
            for (int b = 0; b < NB; b++) begin
                if (wr_idx == CW'(b))
                    shadow[8*b +: 8] <= i_cfg_data;
            end
        end
    end

    assign sum = {1'b0, acc} + {1'b0, ftw};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            carry_d <= 1'b0;
            v1      <= 1'b0;
            o_phase <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            v1 <= i_ce;
            if (i_phase_clr) begin
                acc     <= '0;
                carry_d <= 1'b0;
            end else if (i_ce) begin
                acc     <= sum[PW-1:0];
                carry_d <= sum[PW];
            end
            o_valid <= v1;
            if (v1) begin
                o_phase <= acc + poff;
                o_wrap  <= carry_d;
            end else begin
                o_wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: cycle table plus reset/wrap sequences.
module tb_nco_phase_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_ce;
    logic        i_cfg_valid;
    logic        i_cfg_sel;
    logic [7:0]  i_cfg_data;
    logic        o_cfg_ready;
    logic        o_cfg_commit;
    logic        i_phase_clr;
    logic [23:0] o_phase;
    logic        o_valid;
    logic        o_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ce;
        logic        clr;
        logic        cv;
        logic        sel;
        logic [7:0]  data;
        logic        ev;
        logic [23:0] ephase;
        logic        ewrap;
        logic        ecommit;
        logic        eready;
    } vec_t;

    vec_t tbl[$];

    nco_phase_gen #(.PW(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_ce         (i_ce),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_sel    (i_cfg_sel),
        .i_cfg_data   (i_cfg_data),
        .o_cfg_ready  (o_cfg_ready),
        .o_cfg_commit (o_cfg_commit),
        .i_phase_clr  (i_phase_clr),
        .o_phase      (o_phase),
        .o_valid      (o_valid),
        .o_wrap       (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ce, clr, cv, sel,
                       input logic [7:0] d,
                       input logic ev,
                       input logic [23:0] ph,
                       input logic wr, cm, rdy);
        vec_t v;
        v.ce = ce; v.clr = clr; v.cv = cv; v.sel = sel;
        v.data = d; v.ev = ev; v.ephase = ph;
        v.ewrap = wr; v.ecommit = cm; v.eready = rdy;
        tbl.push_back(v);
    endtask

    task automatic step(input logic ce, clr, cv, sel,
                        input logic [7:0] d);
        i_ce        = ce;
        i_phase_clr = clr;
        i_cfg_valid = cv;
        i_cfg_sel   = sel;
        i_cfg_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {4'h0, o_valid, o_phase, o_wrap,
                o_cfg_commit, o_cfg_ready};
    endfunction

    function automatic logic [31:0] pack(input logic v,
                                         input logic [23:0] p,
                                         input logic w, c, r);
        return {4'h0, v, p, w, c, r};
    endfunction

    initial begin
        reset = 1'b1;
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("reset_outs", outs(), pack(0, 0, 0, 0, 0));
        reset = 1'b0;
        step(0, 0, 0, 0, 8'h00);
        chk("post_reset", outs(), pack(0, 0, 0, 0, 1));

        // FTW = 0x000100, first ce in commit cycle uses old FTW
        add(0,0,1,0,8'h00, 0,24'h000000,0,0,1);
        add(0,0,1,0,8'h01, 0,24'h000000,0,0,1);
        add(0,0,1,0,8'h00, 0,24'h000000,0,1,0);
        add(1,0,0,0,8'h00, 0,24'h000000,0,0,1);
        add(1,0,0,0,8'h00, 1,24'h000000,0,0,1);
        add(1,0,0,0,8'h00, 1,24'h000100,0,0,1);
        // POFF = 0x400000 loaded while accumulating
        add(1,0,1,1,8'h00, 1,24'h000200,0,0,1);
        add(1,0,1,1,8'h00, 1,24'h000300,0,0,1);
        add(1,0,1,1,8'h40, 1,24'h000400,0,1,0);
        add(1,0,0,0,8'h00, 1,24'h000500,0,0,1);
        add(1,0,0,0,8'h00, 1,24'h400600,0,0,1);
        add(1,0,0,0,8'h00, 1,24'h400700,0,0,1);
        // sel switch aborts FTW word, POFF = 0x332211
        add(0,0,1,0,8'hAA, 1,24'h400800,0,0,1);
        add(0,0,1,1,8'h11, 0,24'h400800,0,0,1);
        add(0,0,1,1,8'h22, 0,24'h400800,0,0,1);
        add(0,0,1,1,8'h33, 0,24'h400800,0,1,0);
        add(1,0,0,0,8'h00, 0,24'h400800,0,0,1);
        add(1,0,0,0,8'h00, 1,24'h332B11,0,0,1);
        // clear with ce, then ce gaps
        add(1,1,0,0,8'h00, 1,24'h332C11,0,0,1);
        add(0,0,0,0,8'h00, 1,24'h332211,0,0,1);
        add(1,0,0,0,8'h00, 0,24'h332211,0,0,1);
        add(0,0,0,0,8'h00, 1,24'h332311,0,0,1);
        add(0,0,0,0,8'h00, 0,24'h332311,0,0,1);

        foreach (tbl[i]) begin
            step(tbl[i].ce, tbl[i].clr, tbl[i].cv,
                 tbl[i].sel, tbl[i].data);
            chk($sformatf("vec%0d", i), outs(),
                pack(tbl[i].ev, tbl[i].ephase, tbl[i].ewrap,
                     tbl[i].ecommit, tbl[i].eready));
        end

        // reset in the middle of an FTW load
        step(0, 0, 1, 0, 8'h55);
        step(0, 0, 1, 0, 8'h66);
        reset = 1'b1;
        step(0, 0, 0, 0, 8'h00);
        chk("midload_reset", outs(), pack(0, 0, 0, 0, 0));
        reset = 1'b0;
        step(0, 0, 0, 0, 8'h00);
        chk("midload_after", outs(), pack(0, 0, 0, 0, 1));
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        chk("ftw_zero", outs(), pack(1, 0, 0, 0, 1));
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("idle_again", outs(), pack(0, 0, 0, 0, 1));

        // fresh load FTW = 0x800000
        step(0, 0, 1, 0, 8'h00);
        chk("fresh_b0", {31'h0, o_cfg_commit}, 32'h0);
        step(0, 0, 1, 0, 8'h00);
        chk("fresh_b1", {31'h0, o_cfg_commit}, 32'h0);
        step(0, 0, 1, 0, 8'h80);
        chk("fresh_commit", outs(), pack(0, 0, 0, 1, 0));
        step(0, 0, 0, 0, 8'h00);
        chk("fresh_done", outs(), pack(0, 0, 0, 0, 1));

        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 0, 0, 8'h00);
            if (k >= 2)
                chk($sformatf("wrap%0d", k), outs(),
                    pack(1, (k % 2 == 0) ? 24'h800000 : 24'h0,
                         (k % 2 == 1), 0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
